// File: rtl/mem_arbiter_if.sv
// Memory request/response port shared by the caches, the arbiter and memory.
// The master side issues requests and write data; the slave side accepts them
// and returns read response beats.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic                   mem_req_rw;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the IC and DC caches alternating ownership of one
// external memory port, one whole transaction (write + data beat, or read +
// response burst) at a time. All handshakes pass through combinationally.
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int READ_BEATS    = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem,
    output logic          protocol_error
);
    localparam int BEAT_BITS = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(READ_BEATS - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] BEAT_ZERO = BEAT_BITS'(0);
    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_DATA = 2'd1,
        ST_READ_RESP  = 2'd2
    } state_t;

    state_t                     state_r, state_nxt_s;
    logic                       ptr_r, ptr_nxt_s;
    logic                       owner_r, owner_nxt_s;
    logic [BEAT_BITS-1:0]       beat_r, beat_nxt_s;
    logic                       perr_r, perr_nxt_s;

    logic                       ic_req_ready_s, dc_req_ready_s;
    logic                       ic_data_ready_s, dc_data_ready_s;
    logic                       ic_resp_valid_s, dc_resp_valid_s;
    logic                       req_valid_s, data_valid_s;
    logic [MEM_ADDR_BITS-1:0]   sel_addr_s;
    logic [MEM_DATA_BITS-1:0]   sel_bits_s;
    logic [MEM_DATA_BITS/8-1:0] sel_mask_s;

    // Request address/rw follow the offered port; write data follows the owner.
    assign sel_addr_s = (ptr_r == PORT_DC) ? dc.mem_req_addr : ic.mem_req_addr;
    assign sel_bits_s = (owner_r == PORT_DC) ? dc.mem_req_data_bits : ic.mem_req_data_bits;
    assign sel_mask_s = (owner_r == PORT_DC) ? dc.mem_req_data_mask : ic.mem_req_data_mask;

    // State registers: FSM state, round-robin pointer, owner, beat count, error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= PORT_DC;
            owner_r <= PORT_IC;
            beat_r  <= BEAT_ZERO;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
            beat_r  <= beat_nxt_s;
            perr_r  <= perr_nxt_s;
        end
    end

    // Next-state logic and steering of the handshake signals.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        owner_nxt_s     = owner_r;
        beat_nxt_s      = beat_r;
        perr_nxt_s      = perr_r;
        ic_req_ready_s  = 1'b0;
        dc_req_ready_s  = 1'b0;
        ic_data_ready_s = 1'b0;
        dc_data_ready_s = 1'b0;
        ic_resp_valid_s = 1'b0;
        dc_resp_valid_s = 1'b0;
        req_valid_s     = 1'b0;
        data_valid_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Ready is offered from ptr alone so it never depends on a valid.
                ic_req_ready_s = (ptr_r == PORT_IC) && mem.mem_req_ready;
                dc_req_ready_s = (ptr_r == PORT_DC) && mem.mem_req_ready;
                req_valid_s    = (ptr_r == PORT_DC) ? dc.mem_req_valid : ic.mem_req_valid;
                if (req_valid_s && mem.mem_req_ready) begin
                    owner_nxt_s = ptr_r;
                    if ((ptr_r == PORT_DC) ? dc.mem_req_rw : ic.mem_req_rw) begin
                        state_nxt_s = ST_WRITE_DATA;
                    end else begin
                        state_nxt_s = ST_READ_RESP;
                        beat_nxt_s  = BEAT_ZERO;
                    end
                end else begin
                    ptr_nxt_s = ~ptr_r;
                end
            end
            ST_WRITE_DATA: begin
                ic_data_ready_s = (owner_r == PORT_IC) && mem.mem_req_data_ready;
                dc_data_ready_s = (owner_r == PORT_DC) && mem.mem_req_data_ready;
                data_valid_s    = (owner_r == PORT_DC) ? dc.mem_req_data_valid
                                                       : ic.mem_req_data_valid;
                if (data_valid_s && mem.mem_req_data_ready) begin
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = ~owner_r;
                end else begin
                    state_nxt_s = ST_WRITE_DATA;
                end
            end
            ST_READ_RESP: begin
                ic_resp_valid_s = (owner_r == PORT_IC) && mem.mem_resp_valid;
                dc_resp_valid_s = (owner_r == PORT_DC) && mem.mem_resp_valid;
                if (mem.mem_resp_valid) begin
                    beat_nxt_s = beat_r + BEAT_ONE;
                    if (beat_r == LAST_BEAT) begin
                        state_nxt_s = ST_IDLE;
                        ptr_nxt_s   = ~owner_r;
                    end else begin
                        state_nxt_s = ST_READ_RESP;
                    end
                end else begin
                    beat_nxt_s = beat_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A beat with no read outstanding is dropped and latched as an error.
        if (mem.mem_resp_valid && (state_r != ST_READ_RESP)) begin
            perr_nxt_s = 1'b1;
        end else begin
            perr_nxt_s = perr_nxt_s;
        end
    end

    // Handshake outputs are held low while reset is asserted.
    assign ic.mem_req_ready      = ic_req_ready_s & reset;
    assign dc.mem_req_ready      = dc_req_ready_s & reset;
    assign ic.mem_req_data_ready = ic_data_ready_s & reset;
    assign dc.mem_req_data_ready = dc_data_ready_s & reset;
    assign ic.mem_resp_valid     = ic_resp_valid_s & reset;
    assign dc.mem_resp_valid     = dc_resp_valid_s & reset;
    assign ic.mem_resp_data      = mem.mem_resp_data;
    assign dc.mem_resp_data      = mem.mem_resp_data;

    assign mem.mem_req_valid      = req_valid_s & reset;
    assign mem.mem_req_addr       = sel_addr_s;
    assign mem.mem_req_rw         = (ptr_r == PORT_DC) ? dc.mem_req_rw : ic.mem_req_rw;
    assign mem.mem_req_data_valid = data_valid_s & reset;
    assign mem.mem_req_data_bits  = sel_bits_s;
    assign mem.mem_req_data_mask  = sel_mask_s;

    assign protocol_error = perr_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants, response beats and write
// beats are queued as stimulus is driven and checked when the DUT shows them.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    logic protocol_error;

    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) ic_if ();
    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) dc_if ();
    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) mem_if ();

    mem_arbiter #(.MEM_ADDR_BITS(28), .MEM_DATA_BITS(128), .READ_BEATS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic             (ic_if),
        .dc             (dc_if),
        .mem            (mem_if),
        .protocol_error (protocol_error)
    );

    typedef struct { logic port; logic [27:0] addr; logic rw; } grant_t;
    typedef struct { logic port; logic [127:0] data; } resp_t;
    typedef struct { logic [127:0] data; logic [15:0] mask; } wr_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    wr_t    wr_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on a port and wait (bounded) for it to be accepted.
    task automatic request(input logic port, input logic rw, input logic [27:0] addr);
        grant_t g;
        bit got;
        got = 1'b0;
        g.port = port; g.addr = addr; g.rw = rw;
        grant_q.push_back(g);
        if (port) begin
            dc_if.mem_req_valid = 1'b1; dc_if.mem_req_rw = rw; dc_if.mem_req_addr = addr;
        end else begin
            ic_if.mem_req_valid = 1'b1; ic_if.mem_req_rw = rw; ic_if.mem_req_addr = addr;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if ((port ? dc_if.mem_req_ready : ic_if.mem_req_ready) === 1'b1) got = 1'b1;
            step();
        end
        ic_if.mem_req_valid = 1'b0;
        dc_if.mem_req_valid = 1'b0;
        check("req_timeout", {127'd0, got}, 128'd1);
    endtask

    // Drive one response beat expected at the given port; no grant may be offered.
    task automatic beat(input logic port, input logic [127:0] data);
        resp_t r;
        r.port = port; r.data = data;
        resp_q.push_back(r);
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data  = data;
        @(negedge clk);
        check("busy_ic_ready", {127'd0, ic_if.mem_req_ready}, 128'd0);
        check("busy_dc_ready", {127'd0, dc_if.mem_req_ready}, 128'd0);
        step();
        mem_if.mem_resp_valid = 1'b0;
    endtask

    // Monitor: compare observed grants, response beats and write beats with the scoreboard.
    always @(negedge clk) begin
        grant_t g;
        resp_t  r;
        wr_t    w;
        if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
            if (grant_q.size() == 0) begin
                check("grant_unexpected", 128'd1, {127'd0, grant_q.size() != 0});
            end else begin
                g = grant_q.pop_front();
                check("grant_port", {127'd0, dc_if.mem_req_ready}, {127'd0, g.port});
                check("grant_addr", {100'd0, mem_if.mem_req_addr}, {100'd0, g.addr});
                check("grant_rw", {127'd0, mem_if.mem_req_rw}, {127'd0, g.rw});
            end
        end
        if (ic_if.mem_resp_valid || dc_if.mem_resp_valid) begin
            check("resp_both", {127'd0, ic_if.mem_resp_valid & dc_if.mem_resp_valid}, 128'd0);
            if (resp_q.size() == 0) begin
                check("resp_unexpected", {127'd0, ic_if.mem_resp_valid | dc_if.mem_resp_valid}, 128'd0);
            end else begin
                r = resp_q.pop_front();
                check("resp_port", {127'd0, dc_if.mem_resp_valid}, {127'd0, r.port});
                check("resp_data", r.port ? dc_if.mem_resp_data : ic_if.mem_resp_data, r.data);
            end
        end
        if (mem_if.mem_req_data_valid && mem_if.mem_req_data_ready) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {127'd0, mem_if.mem_req_data_valid}, 128'd0);
            end else begin
                w = wr_q.pop_front();
                check("wr_data", mem_if.mem_req_data_bits, w.data);
                check("wr_mask", {112'd0, mem_if.mem_req_data_mask}, {112'd0, w.mask});
            end
        end
    end

    initial begin
        logic exp_order [4];
        wr_t w;
        bit got;
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;

        reset = 1'b0;
        ic_if.mem_req_valid = 1'b1; ic_if.mem_req_addr = 28'd0; ic_if.mem_req_rw = 1'b0;
        ic_if.mem_req_data_valid = 1'b0; ic_if.mem_req_data_bits = 128'd0; ic_if.mem_req_data_mask = 16'd0;
        dc_if.mem_req_valid = 1'b1; dc_if.mem_req_addr = 28'd0; dc_if.mem_req_rw = 1'b0;
        dc_if.mem_req_data_valid = 1'b0; dc_if.mem_req_data_bits = 128'd0; dc_if.mem_req_data_mask = 16'd0;
        mem_if.mem_req_ready = 1'b1; mem_if.mem_req_data_ready = 1'b1;
        mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = 128'd0;

        // Reset held with everything asserted: all steered handshakes stay low.
        repeat (3) begin
            @(negedge clk);
            check("rst_ic_ready", {127'd0, ic_if.mem_req_ready}, 128'd0);
            check("rst_dc_ready", {127'd0, dc_if.mem_req_ready}, 128'd0);
            check("rst_ic_resp", {127'd0, ic_if.mem_resp_valid}, 128'd0);
            check("rst_dc_resp", {127'd0, dc_if.mem_resp_valid}, 128'd0);
            check("rst_perr", {127'd0, protocol_error}, 128'd0);
        end
        step();
        ic_if.mem_req_valid = 1'b0; dc_if.mem_req_valid = 1'b0; mem_if.mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_dc_ready", {127'd0, dc_if.mem_req_ready}, 128'd1);
        check("post_rst_ic_ready", {127'd0, ic_if.mem_req_ready}, 128'd0);
        step();

        // DC read with a gap after the second beat.
        request(1'b1, 1'b0, 28'h0000010);
        beat(1'b1, 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A0);
        beat(1'b1, 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A1);
        step();
        beat(1'b1, 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A2);
        beat(1'b1, 128'h0123_4567_89AB_CDEF_0000_0000_0000_00A3);
        @(negedge clk);
        check("rd_ic_offered", {127'd0, ic_if.mem_req_ready}, 128'd1);
        check("rd_dc_not_offered", {127'd0, dc_if.mem_req_ready}, 128'd0);
        step();

        // IC write with data_ready held low for two cycles.
        mem_if.mem_req_data_ready = 1'b0;
        request(1'b0, 1'b1, 28'h0000020);
        repeat (2) begin
            @(negedge clk);
            check("wr_hold_ic_dready", {127'd0, ic_if.mem_req_data_ready}, 128'd0);
            check("wr_hold_dvalid", {127'd0, mem_if.mem_req_data_valid}, 128'd0);
            step();
        end
        mem_if.mem_req_data_ready = 1'b1;
        ic_if.mem_req_data_valid = 1'b1;
        ic_if.mem_req_data_bits = 128'hDEADBEEF;
        ic_if.mem_req_data_mask = 16'h000F;
        dc_if.mem_req_data_bits = 128'h5555;
        dc_if.mem_req_data_mask = 16'hFFF0;
        w.data = 128'hDEADBEEF; w.mask = 16'h000F;
        wr_q.push_back(w);
        @(negedge clk);
        check("wr_ic_dready", {127'd0, ic_if.mem_req_data_ready}, 128'd1);
        check("wr_dc_dready", {127'd0, dc_if.mem_req_data_ready}, 128'd0);
        step();
        ic_if.mem_req_data_valid = 1'b0;
        @(negedge clk);
        check("wr_idle_dc_ready", {127'd0, dc_if.mem_req_ready}, 128'd1);
        check("wr_q_drained", {96'd0, wr_q.size()}, 128'd0);
        step();
        step();

        // Contention: both ports request reads continuously.
        for (int t = 0; t < 4; t++) begin
            grant_t g;
            g.port = exp_order[t]; g.rw = 1'b0;
            g.addr = exp_order[t] ? 28'h0000200 : 28'h0000100;
            grant_q.push_back(g);
        end
        ic_if.mem_req_valid = 1'b1; ic_if.mem_req_rw = 1'b0; ic_if.mem_req_addr = 28'h0000100;
        dc_if.mem_req_valid = 1'b1; dc_if.mem_req_rw = 1'b0; dc_if.mem_req_addr = 28'h0000200;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int i = 0; i < 6 && !got; i++) begin
                @(negedge clk);
                if (mem_if.mem_req_valid && mem_if.mem_req_ready) got = 1'b1;
                step();
            end
            check("cont_timeout", {127'd0, got}, 128'd1);
            if (t == 3) dc_if.mem_req_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                beat(exp_order[t], {96'hC0DE_0000_0000_0000_0000_0000, 24'd0, t[3:0], b[3:0]});
            end
        end

        // Lone IC requester with ptr at DC: one bubble, then accepted.
        grant_q.push_back('{port: 1'b0, addr: 28'h0000100, rw: 1'b0});
        @(negedge clk);
        check("lone_bubble", {127'd0, ic_if.mem_req_ready}, 128'd0);
        step();
        @(negedge clk);
        check("lone_grant", {127'd0, ic_if.mem_req_ready}, 128'd1);
        step();
        ic_if.mem_req_valid = 1'b0;
        for (int b = 0; b < 4; b++) beat(1'b0, {120'h7, b[7:0]});

        // Stray beat in IDLE: dropped and flagged.
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data = 128'hBAD;
        @(negedge clk);
        check("stray_ic_resp", {127'd0, ic_if.mem_resp_valid}, 128'd0);
        check("stray_dc_resp", {127'd0, dc_if.mem_resp_valid}, 128'd0);
        step();
        mem_if.mem_resp_valid = 1'b0;
        @(negedge clk);
        check("stray_perr", {127'd0, protocol_error}, 128'd1);
        step();

        // Reset in the middle of a DC read burst.
        request(1'b1, 1'b0, 28'h0000300);
        beat(1'b1, 128'hF00D);
        reset = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        @(negedge clk);
        check("midrst_perr", {127'd0, protocol_error}, 128'd0);
        check("midrst_dc_resp", {127'd0, dc_if.mem_resp_valid}, 128'd0);
        step();
        mem_if.mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_idle_dc_ready", {127'd0, dc_if.mem_req_ready}, 128'd1);
        check("midrst_perr_clear", {127'd0, protocol_error}, 128'd0);
        step();
        mem_if.mem_resp_valid = 1'b1;
        @(negedge clk);
        check("late_dc_resp", {127'd0, dc_if.mem_resp_valid}, 128'd0);
        step();
        mem_if.mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_perr", {127'd0, protocol_error}, 128'd1);

        check("grant_q_empty", {96'd0, grant_q.size()}, 128'd0);
        check("resp_q_empty", {96'd0, resp_q.size()}, 128'd0);
        check("wr_q_empty", {96'd0, wr_q.size()}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
